// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and the hex-to-segment table for the 7-segment scan controller.
// All segment values are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam logic [7:0] ANODE_OFF   = 8'hFF;
    localparam logic [7:0] CATHODE_OFF = 8'hFF;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Bus-side write port plus board-side pin bundle of the display controller.
interface seg7_scan_ctrl_if #(
    parameter int NUM_DIGITS = 8
);
    logic                  enable;
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  clr;
    logic [NUM_DIGITS-1:0] dp_mask;
    logic [7:0]            cathode_array;
    logic [NUM_DIGITS-1:0] anode_array;
    logic                  frame_tick;

    modport master (
        output enable, wr_en, wr_data, clr, dp_mask,
        input  cathode_array, anode_array, frame_tick
    );

    modport slave (
        input  enable, wr_en, wr_data, clr, dp_mask,
        output cathode_array, anode_array, frame_tick
    );
endinterface

// File: rtl/seg7_scan_ctrl_hex_decoder.sv
// Combinational nibble to active-low 7-segment decoder.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = hex_to_seg(nibble_i);
endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 8-digit 7-segment scan controller: byte-shift digit buffer,
// prescaled digit scan with per-slot blanking, leading-zero suppression.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int CLK_DIV     = 1000,
    parameter int BLANK_CYC   = 4,
    parameter int LZ_SUPPRESS = 1
) (
    input  logic            clk,
    input  logic            resetn,
    seg7_scan_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int BUF_W = 4 * NUM_DIGITS;

    logic [15:0]           presc_q, presc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BUF_W-1:0]      buf_q, buf_d;
    logic [7:0]            cathode_q, cathode_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic                  tick_q, tick_d;

    logic [3:0]            sel_nib;
    logic [6:0]            sel_seg;
    logic [NUM_DIGITS-1:0] lz_mask;

    assign sel_nib = buf_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decoder u_dec (
        .nibble_i (sel_nib),
        .seg_o    (sel_seg)
    );

    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        lz_mask = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            lz_mask[i] = (LZ_SUPPRESS != 0) && ((buf_q >> (4 * i)) == '0);
        end
    end

    always_comb begin
        presc_d   = presc_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        anode_d   = ANODE_OFF;
        cathode_d = CATHODE_OFF;
        tick_d    = 1'b0;

        if (bus.clr) begin
            buf_d = '0;
        end
        if (bus.wr_en) begin
            buf_d = {buf_d[BUF_W-9:0], bus.wr_data};
        end

        if (bus.enable) begin
            if (presc_q == 16'(CLK_DIV - 1)) begin
                presc_d = '0;
                if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                    idx_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end else begin
                presc_d = presc_q + 16'd1;
            end

            if (presc_q >= 16'(BLANK_CYC)) begin
                anode_d   = ~(NUM_DIGITS'(1) << idx_q);
                cathode_d = {~bus.dp_mask[idx_q], lz_mask[idx_q] ? SEG_BLANK : sel_seg};
            end
        end else begin
            presc_d = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            presc_q   <= '0;
            idx_q     <= '0;
            buf_q     <= '0;
            anode_q   <= ANODE_OFF;
            cathode_q <= CATHODE_OFF;
            tick_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            buf_q     <= buf_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.anode_array   = anode_q;
    assign bus.cathode_array = cathode_q;
    assign bus.frame_tick    = tick_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed scenarios plus random traffic,
// every cycle compared against a time-based reference model of the display.
module tb_seg7_scan_ctrl;
    localparam int ND    = 8;
    localparam int DIV   = 10;
    localparam int BLANK = 2;

    logic clk;
    logic resetn;
    int   n_assert = 0;
    int   n_fail   = 0;

    seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus_if ();

    seg7_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .CLK_DIV     (DIV),
        .BLANK_CYC   (BLANK),
        .LZ_SUPPRESS (1)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: display position is a pure function of enabled cycles since scan start.
    logic [6:0] seg_tab [16];
    initial begin
        seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
        seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
        seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
        seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
    end

    int         cnt_m;
    logic [3:0] dig_m [ND];
    logic [7:0] exp_an, exp_cat;
    logic       exp_ft;

    function automatic logic [7:0] model_an(input int c);
        int p = c % DIV;
        int d = (c / DIV) % ND;
        if (p < BLANK) return 8'hFF;
        return ~(8'(1) << d);
    endfunction

    function automatic logic [7:0] model_cat(input int c, input logic [7:0] dp);
        int p = c % DIV;
        int d = (c / DIV) % ND;
        logic visible;
        if (p < BLANK) return 8'hFF;
        visible = (d == 0);
        for (int j = d; j < ND; j++) if (dig_m[j] != 4'h0) visible = 1'b1;
        return {~dp[d], visible ? seg_tab[dig_m[d]] : 7'h7F};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_m   <= 0;
            exp_an  <= 8'hFF;
            exp_cat <= 8'hFF;
            exp_ft  <= 1'b0;
            for (int i = 0; i < ND; i++) dig_m[i] <= 4'h0;
        end else begin
            if (bus_if.enable) begin
                exp_an  <= model_an(cnt_m);
                exp_cat <= model_cat(cnt_m, bus_if.dp_mask);
                exp_ft  <= (cnt_m % (DIV * ND)) == (DIV * ND - 1);
                cnt_m   <= cnt_m + 1;
            end else begin
                exp_an  <= 8'hFF;
                exp_cat <= 8'hFF;
                exp_ft  <= 1'b0;
                cnt_m   <= 0;
            end
            for (int i = 0; i < ND; i++) begin
                if (bus_if.wr_en)
                    dig_m[i] <= (i == 0) ? bus_if.wr_data[3:0] :
                                (i == 1) ? bus_if.wr_data[7:4] :
                                (bus_if.clr ? 4'h0 : dig_m[(i + ND - 2) % ND]);
                else if (bus_if.clr)
                    dig_m[i] <= 4'h0;
            end
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; outputs compared to the model on the falling edge, inputs change afterwards.
    task automatic step();
        @(negedge clk);
        chk("anode", bus_if.anode_array, exp_an);
        chk("cathode", bus_if.cathode_array, exp_cat);
        chk("frame_tick", {7'b0, bus_if.frame_tick}, {7'b0, exp_ft});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = b;
        step();
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic wait_anode(input logic [7:0] target, input string tag);
        for (int i = 0; i < 4 * DIV * ND; i++) begin
            step();
            if (bus_if.anode_array === target) break;
        end
        chk(tag, bus_if.anode_array, target);
    endtask

    int lit_cnt, tick_cnt, first_tick, second_tick;

    initial begin
        resetn         = 1'b0;
        bus_if.enable  = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = 8'h00;
        bus_if.clr     = 1'b0;
        bus_if.dp_mask = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_anode", bus_if.anode_array, 8'hFF);
        chk("reset_cathode", bus_if.cathode_array, 8'hFF);
        chk("reset_tick", {7'b0, bus_if.frame_tick}, 8'h00);
        resetn = 1'b1;
        run(2);

        // Four bytes fill digits 7..0 with 1..8
        bus_if.enable = 1'b1;
        write_byte(8'h12);
        write_byte(8'h34);
        write_byte(8'h56);
        write_byte(8'h78);
        wait_anode(8'hFE, "seek_d0");
        chk("digit0_is_8", bus_if.cathode_array, 8'h80);
        wait_anode(8'h7F, "seek_d7");
        chk("digit7_is_1", bus_if.cathode_array, 8'hF9);
        lit_cnt = 0;
        for (int i = 0; i < DIV * ND; i++) begin
            step();
            if (bus_if.anode_array === 8'hFE) lit_cnt++;
        end
        chk("digit0_lit_cycles", 8'(lit_cnt), 8'd8);

        // Asynchronous reset in the middle of a slot
        wait_anode(8'hF7, "seek_d3");
        #1 resetn = 1'b0;
        #1;
        chk("async_anode", bus_if.anode_array, 8'hFF);
        chk("async_cathode", bus_if.cathode_array, 8'hFF);
        run(2);
        resetn = 1'b1;
        for (int i = 0; i < 4 * DIV; i++) begin
            step();
            if (bus_if.anode_array !== 8'hFF) break;
        end
        chk("first_after_reset", bus_if.anode_array, 8'hFE);

        // Leading-zero suppression with a single byte
        bus_if.clr = 1'b1;
        step();
        bus_if.clr = 1'b0;
        write_byte(8'h05);
        wait_anode(8'hFE, "seek_lz_d0");
        chk("lz_digit0", bus_if.cathode_array, 8'h92);
        for (int i = 0; i < DIV * ND; i++) begin
            step();
            if (bus_if.anode_array === 8'hFE)
                chk("lz_digit0_frame", bus_if.cathode_array, 8'h92);
            else if (bus_if.anode_array !== 8'hFF)
                chk("lz_upper_blank", bus_if.cathode_array, 8'hFF);
        end

        // Disable mid-slot, then re-enable
        wait_anode(8'hFB, "seek_d2");
        bus_if.enable = 1'b0;
        step();
        chk("disable_dark", bus_if.anode_array, 8'hFF);
        run(3);
        bus_if.enable = 1'b1;
        step();
        chk("reen_blank1", bus_if.anode_array, 8'hFF);
        step();
        chk("reen_blank2", bus_if.anode_array, 8'hFF);
        step();
        chk("reen_digit0", bus_if.anode_array, 8'hFE);

        // Simultaneous clear and write
        bus_if.clr = 1'b1;
        write_byte(8'hAB);
        bus_if.clr = 1'b0;
        wait_anode(8'hFE, "seek_ab_d0");
        chk("ab_digit0", bus_if.cathode_array, 8'h83);
        wait_anode(8'hFD, "seek_ab_d1");
        chk("ab_digit1", bus_if.cathode_array, 8'h88);
        wait_anode(8'hFB, "seek_ab_d2");
        chk("ab_digit2", bus_if.cathode_array, 8'hFF);

        // Frame tick cadence and decimal point on digit 0
        bus_if.dp_mask = 8'h01;
        tick_cnt = 0;
        first_tick = -1;
        second_tick = -1;
        for (int i = 0; i < 10 * DIV * ND; i++) begin
            step();
            if (bus_if.frame_tick === 1'b1) begin
                tick_cnt++;
                if (first_tick < 0) first_tick = i;
                else if (second_tick < 0) second_tick = i;
            end
            if (i < DIV * ND)
                chk("dp_only_digit0", {7'b0, bus_if.cathode_array[7]},
                    {7'b0, bus_if.anode_array !== 8'hFE});
        end
        chk("tick_count", 8'(tick_cnt), 8'd10);
        chk("tick_period", 8'(second_tick - first_tick), 8'(DIV * ND));

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bus_if.wr_en   = ($urandom_range(7) == 0);
            bus_if.wr_data = 8'($urandom);
            bus_if.clr     = ($urandom_range(40) == 0);
            bus_if.dp_mask = 8'($urandom);
            if ($urandom_range(60) == 0) bus_if.enable = ~bus_if.enable;
            step();
        end
        bus_if.wr_en = 1'b0;
        bus_if.clr   = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
